// File: rtl/branch_resolve_ex.sv
// EX-stage branch resolution: computes branch/jump targets, registers the redirect
// decision into EX/MEM, and squashes SQUASH_N wrong-path instructions after a redirect.
module branch_resolve_ex #(
  parameter int ADDR_W   = 32,
  parameter int IMM_W    = 16,
  parameter int SQUASH_N = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] PostPc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [25:0]       jidx,
  input  logic              is_beq,
  input  logic              is_bne,
  input  logic              is_jmp,
  input  logic              zero,
  output logic              valid_out,
  output logic              taken_out,
  output logic [ADDR_W-1:0] target_out,
  output logic              squash_out,
  output logic              misalign_out,
  output logic [CNT_W-1:0]  redirect_cnt
);

  typedef enum logic {IDLE, SQUASH} state_e;

  // Region bits above the 28-bit jump field come from PostPc; empty when ADDR_W <= 28.
  localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'(28'hFFF_FFFF);

  state_e            state_q;
  logic [2:0]        sq_cnt_q;
  logic              valid_q, taken_q, misalign_q;
  logic [ADDR_W-1:0] target_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              eff_valid;
  logic              taken_d;
  logic              misalign_d;
  logic [ADDR_W-1:0] br_off, br_tgt, jmp_tgt, target_d;

  assign squash_out = (state_q == SQUASH);
  assign eff_valid  = valid_in & ~squash_out;
  assign taken_d    = eff_valid & ((is_beq & zero) | (is_bne & ~zero) | is_jmp);

  // Size cast sign-extends (or truncates) the immediate to the address width.
  assign br_off  = ADDR_W'($signed(imm));
  assign br_tgt  = PostPc + (br_off << 2);
  assign jmp_tgt = (PostPc & HI_MASK) | ADDR_W'({jidx, 2'b00});

  // NOTE: default assignment first so every path drives target_d and no latch is inferred.
  always_comb begin
    target_d = PostPc;
    if (taken_d) target_d = is_jmp ? jmp_tgt : br_tgt;
  end

  assign misalign_d = taken_d & (target_d[1:0] != 2'b00);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sq_cnt_q   <= '0;
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      misalign_q <= 1'b0;
      target_q   <= '0;
      cnt_q      <= '0;
    end else if (flush_in) begin
      state_q    <= IDLE;
      sq_cnt_q   <= '0;
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!stall_in) begin
      valid_q    <= eff_valid;
      taken_q    <= taken_d;
      target_q   <= target_d;
      misalign_q <= misalign_d;
      if (taken_d && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        // Enter SQUASH on the edge that registers the redirect, so the very next
        // instruction in EX is already treated as wrong-path.
        IDLE: if (taken_d) begin
          state_q  <= SQUASH;
          sq_cnt_q <= 3'(SQUASH_N);
        end
        SQUASH: if (valid_in) begin
          if (sq_cnt_q == 3'd1) begin
            state_q  <= IDLE;
            sq_cnt_q <= '0;
          end else begin
            sq_cnt_q <= sq_cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_out    = valid_q;
  assign taken_out    = taken_q;
  assign target_out   = target_q;
  assign misalign_out = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ex.sv
// Scoreboard bench for branch_resolve_ex: a 32-bit default instance and an 8-bit,
// 2-bit-counter instance share stimulus; a behavioural model predicts both.
module tb_branch_resolve_ex;

  localparam int SQ_N = 2;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic        mis;
    logic [31:0] target;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, stall_in, flush_in;
  logic [31:0] pc;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic        is_beq, is_bne, is_jmp, zero;

  logic        valid_out, taken_out, squash_out, misalign_out;
  logic [31:0] target_out;
  logic [15:0] redirect_cnt;

  logic        valid8, taken8, squash8, mis8;
  logic [7:0]  target8;
  logic [1:0]  cnt8;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t m_prev;
  int   m_sq;
  int   m_cnt;

  always #5 clk = ~clk;

  branch_resolve_ex dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
    .PostPc(pc), .imm(imm), .jidx(jidx), .is_beq(is_beq), .is_bne(is_bne), .is_jmp(is_jmp),
    .zero(zero), .valid_out(valid_out), .taken_out(taken_out), .target_out(target_out),
    .squash_out(squash_out), .misalign_out(misalign_out), .redirect_cnt(redirect_cnt)
  );

  branch_resolve_ex #(.ADDR_W(8), .IMM_W(16), .SQUASH_N(SQ_N), .CNT_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
    .PostPc(pc[7:0]), .imm(imm), .jidx(jidx), .is_beq(is_beq), .is_bne(is_bne), .is_jmp(is_jmp),
    .zero(zero), .valid_out(valid8), .taken_out(taken8), .target_out(target8),
    .squash_out(squash8), .misalign_out(mis8), .redirect_cnt(cnt8)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string when);
    check({when, ".valid"},    valid_out,    0);
    check({when, ".taken"},    taken_out,    0);
    check({when, ".target"},   target_out,   0);
    check({when, ".squash"},   squash_out,   0);
    check({when, ".misalign"}, misalign_out, 0);
    check({when, ".cnt"},      redirect_cnt, 0);
    check({when, ".cnt8"},     cnt8,         0);
  endtask

  // Drive one cycle of stimulus, predict the registered result, then compare after the edge.
  task automatic step(input logic v, input logic beq, input logic bne, input logic jmp,
                      input logic z, input logic [31:0] p, input logic [15:0] im,
                      input logic [25:0] ji, input logic st, input logic fl);
    exp_t        e;
    logic        sq, tk;
    logic [31:0] tgt;
    valid_in = v; is_beq = beq; is_bne = bne; is_jmp = jmp; zero = z;
    pc = p; imm = im; jidx = ji; stall_in = st; flush_in = fl;
    #1;
    sq = (m_sq != 0);
    check("squash", squash_out, sq);
    check("squash8", squash8, sq);

    tk = v && !sq && ((beq && z) || (bne && !z) || jmp);
    if (!tk)      tgt = p;
    else if (jmp) tgt = {p[31:28], ji, 2'b00};
    else          tgt = p + {{14{im[15]}}, im, 2'b00};

    e = m_prev;
    if (fl) begin
      e.valid = 1'b0; e.taken = 1'b0; e.mis = 1'b0;
      m_sq = 0;
    end else if (!st) begin
      e.valid  = v && !sq;
      e.taken  = tk;
      e.target = tgt;
      e.mis    = tk && (tgt[1:0] != 2'b00);
      if (tk) begin
        m_cnt++;
        m_sq = SQ_N;
      end else if (sq && v) begin
        m_sq--;
      end
      e.cnt = m_cnt;
    end
    sb.push_back(e);
    m_prev = e;

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("valid",    valid_out,    e.valid);
      check("taken",    taken_out,    e.taken);
      check("target",   target_out,   e.target);
      check("misalign", misalign_out, e.mis);
      check("cnt",      redirect_cnt, e.cnt);
      check("valid8",   valid8,       e.valid);
      check("taken8",   taken8,       e.taken);
      check("target8",  target8,      e.target[7:0]);
      check("misalign8", mis8,        e.mis);
      check("cnt8",     cnt8,         (e.cnt > 3) ? 32'd3 : e.cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    valid_in = 0; stall_in = 0; flush_in = 0; pc = '0; imm = '0; jidx = '0;
    is_beq = 0; is_bne = 0; is_jmp = 0; zero = 0;
    m_prev = '0; m_sq = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    //   v  beq bne jmp z   PostPc        imm      jidx        st fl
    step(1, 0,  1,  0,  1, 32'h0000_0200, 16'h0040, 26'h0,      0, 0); // BNE not taken
    step(1, 1,  0,  0,  1, 32'h0000_0100, 16'h0004, 26'h0,      0, 0); // BEQ taken
    step(1, 1,  0,  0,  1, 32'h0000_0104, 16'h0008, 26'h0,      0, 0); // squashed taken BEQ
    step(0, 0,  0,  0,  0, 32'h0000_0108, 16'h0000, 26'h0,      0, 0); // bubble extends squash
    step(1, 0,  0,  0,  0, 32'h0000_0108, 16'h0000, 26'h0,      0, 0); // last squashed
    step(1, 0,  0,  1,  0, 32'h1234_5678, 16'h0000, 26'h2ABCDEF, 0, 0); // jump taken
    step(1, 1,  0,  0,  1, 32'h0000_5000, 16'h0010, 26'h0,      0, 0); // squashed taken BEQ
    step(1, 0,  1,  0,  0, 32'h0000_5004, 16'h0020, 26'h0,      0, 0); // taken as SQUASH ends: unseen
    step(1, 1,  0,  0,  1, 32'h0000_0000, 16'hFFFF, 26'h0,      0, 0); // negative wrap
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 1, 0, 32'h0000_0700 + 32'(i * 4), 16'h0000, 26'h0000123, 1, 0); // stall
    step(1, 1,  0,  0,  1, 32'h0000_0300, 16'h0001, 26'h0,      0, 0); // squashed
    step(1, 0,  0,  0,  0, 32'h0000_0304, 16'h0000, 26'h0,      0, 0); // squashed, back to IDLE
    step(1, 1,  0,  0,  1, 32'h0000_00FC, 16'h0002, 26'h0,      0, 0); // 8-bit wrap to 0x04
    step(1, 0,  0,  1,  0, 32'h0000_0400, 16'h0000, 26'h0000055, 1, 1); // stall+flush
    step(1, 0,  1,  0,  0, 32'h0000_0102, 16'h0001, 26'h0,      0, 0); // taken, misaligned

    // Asynchronous reset between edges while in SQUASH with five redirects counted.
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    m_prev = '0; m_sq = 0; m_cnt = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    step(1, 0,  0,  1,  0, 32'hA000_0000, 16'h0000, 26'h3FFFFFF, 0, 0); // jump after reset
    step(1, 1,  0,  0,  1, 32'h0000_0010, 16'h0003, 26'h0,      0, 0); // squashed
    step(1, 0,  1,  0,  0, 32'h0000_0014, 16'h0003, 26'h0,      0, 0); // squashed
    step(1, 0,  1,  0,  1, 32'h0000_0040, 16'h0003, 26'h0,      0, 0); // normal, not taken

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
